// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-sequencing controller.
package fetch_pkg;

  localparam int WORD_W = 16;
  localparam logic [WORD_W-1:0] IRQ_VECTOR = 16'h0004;
  localparam logic [WORD_W-1:0] PC_INC     = 16'd2;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

endpackage

// File: rtl/fetch_npc.sv
// Next-PC priority mux: reti > interrupt entry > branch > halt > sequential.
module fetch_npc
  import fetch_pkg::*;
(
  input  logic  boundary_i,   // exec_done seen while in EXEC
  input  logic  halt_st_i,
  input  logic  reti_i,
  input  logic  br_taken_i,
  input  logic  halt_req_i,
  input  logic  irq_i,
  input  logic  irq_en_i,
  input  logic  in_isr_i,
  input  word_t pc_i,
  input  word_t br_target_i,
  input  word_t epc_i,
  output logic  pc_load_o,
  output word_t pc_next_o,
  output logic  irq_entry_o,
  output word_t epc_new_o,
  output logic  go_halt_o
);

  logic irq_ok;
  assign irq_ok = irq_i && irq_en_i && !in_isr_i;

  always_comb begin
    pc_load_o   = 1'b0;
    pc_next_o   = '0;
    irq_entry_o = 1'b0;
    epc_new_o   = '0;
    go_halt_o   = 1'b0;
    if (boundary_i) begin
      if (reti_i) begin
        pc_load_o = 1'b1;
        pc_next_o = {epc_i[WORD_W-1:1], 1'b0};
      end else if (irq_ok) begin
        // A halt retiring together with an interrupt is dropped.
        pc_load_o   = 1'b1;
        pc_next_o   = IRQ_VECTOR;
        irq_entry_o = 1'b1;
        epc_new_o   = br_taken_i ? br_target_i : pc_i;
      end else if (br_taken_i) begin
        pc_load_o = 1'b1;
        pc_next_o = {br_target_i[WORD_W-1:1], 1'b0};
      end else if (halt_req_i) begin
        go_halt_o = 1'b1;
      end
    end else if (halt_st_i && irq_ok) begin
      pc_load_o   = 1'b1;
      pc_next_o   = IRQ_VECTOR;
      irq_entry_o = 1'b1;
      epc_new_o   = pc_i;
    end
  end

endmodule

// File: rtl/fetch_seq.sv
// Instruction sequencer: FETCH/EXEC/HALT FSM, instruction register and
// interrupt return state. mem_req: held from FETCH entry until mem_ack; the
// word is taken in the ack cycle only.
module fetch_seq
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pc_in,
  output logic        pc_load,
  output logic        pc_inc,
  output logic [15:0] pc_next,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic [15:0] ir,
  output logic        ir_valid,
  input  logic        exec_done,
  input  logic        br_taken,
  input  logic [15:0] br_target,
  input  logic        reti,
  input  logic        halt_req,
  input  logic        irq,
  input  logic        irq_en,
  output logic        irq_ack,
  output logic        in_isr,
  output logic [15:0] epc,
  output logic        halted,
  output logic [1:0]  dbg_state
);

  state_e state_q, state_d;
  word_t  ir_q, ir_d;
  word_t  epc_q, epc_d;
  logic   in_isr_q, in_isr_d;

  logic  boundary;
  logic  npc_load, npc_irq, npc_halt;
  word_t npc_next, npc_epc;

  assign boundary = (state_q == ST_EXEC) && exec_done;

  fetch_npc u_npc (
    .boundary_i  (boundary),
    .halt_st_i   (state_q == ST_HALT),
    .reti_i      (reti),
    .br_taken_i  (br_taken),
    .halt_req_i  (halt_req),
    .irq_i       (irq),
    .irq_en_i    (irq_en),
    .in_isr_i    (in_isr_q),
    .pc_i        (pc_in),
    .br_target_i (br_target),
    .epc_i       (epc_q),
    .pc_load_o   (npc_load),
    .pc_next_o   (npc_next),
    .irq_entry_o (npc_irq),
    .epc_new_o   (npc_epc),
    .go_halt_o   (npc_halt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_FETCH;
      ir_q     <= '0;
      epc_q    <= '0;
      in_isr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      epc_q    <= epc_d;
      in_isr_q <= in_isr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH: if (mem_ack) state_d = ST_EXEC;
      ST_EXEC:  if (exec_done) state_d = npc_halt ? ST_HALT : ST_FETCH;
      ST_HALT:  if (npc_irq) state_d = ST_FETCH;
      default:  state_d = ST_FETCH;
    endcase
  end

  always_comb begin
    ir_d     = (state_q == ST_FETCH && mem_ack) ? mem_rdata : ir_q;
    epc_d    = npc_irq ? npc_epc : epc_q;
    in_isr_d = in_isr_q;
    if (npc_irq)              in_isr_d = 1'b1;
    else if (boundary && reti) in_isr_d = 1'b0;
  end

  // Strobes are gated by rst so nothing leaks out during the reset cycle.
  always_comb begin
    mem_req  = 1'b0;
    pc_inc   = 1'b0;
    pc_load  = 1'b0;
    pc_next  = '0;
    ir_valid = 1'b0;
    irq_ack  = 1'b0;
    halted   = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_FETCH: begin
          mem_req = 1'b1;
          pc_inc  = mem_ack;
        end
        ST_EXEC: begin
          ir_valid = 1'b1;
          pc_load  = npc_load;
          pc_next  = npc_next;
          irq_ack  = npc_irq;
        end
        ST_HALT: begin
          halted  = 1'b1;
          pc_load = npc_load;
          pc_next = npc_next;
          irq_ack = npc_irq;
        end
        default: ;
      endcase
    end
  end

  assign mem_addr  = pc_in;
  assign ir        = ir_q;
  assign epc       = epc_q;
  assign in_isr    = in_isr_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fetch_seq.sv
// Cycle-accurate vector bench for fetch_seq with a small PC model around it.
module tb_fetch_seq;
  import fetch_pkg::*;

  typedef struct packed {
    logic rst, ack; logic [15:0] rdata;
    logic done, bt; logic [15:0] tgt;
    logic reti, halt, irq, ien;
  } vin_t;

  typedef struct packed {
    logic req; logic [15:0] addr;
    logic inc, load; logic [15:0] nxt;
    logic irv, iack, isr, hlt;
    logic [15:0] ir, epc;
  } vout_t;

  typedef struct { vin_t i; vout_t o; } vec_t;
  localparam int W = $bits(vout_t);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] pc = 16'h0000;
  logic        pc_load, pc_inc, mem_req, mem_ack = 1'b0;
  logic [15:0] pc_next, mem_addr, mem_rdata = 16'h0, ir, epc;
  logic        ir_valid, exec_done = 1'b0, br_taken = 1'b0, reti = 1'b0;
  logic        halt_req = 1'b0, irq = 1'b0, irq_en = 1'b0;
  logic        irq_ack, in_isr, halted;
  logic [15:0] br_target = 16'h0;
  logic [1:0]  dbg_state;

  logic [W-1:0] exp_q[$];
  vec_t tbl[$];
  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  fetch_seq dut (
    .clk(clk), .rst(rst), .pc_in(pc), .pc_load(pc_load), .pc_inc(pc_inc),
    .pc_next(pc_next), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .ir(ir), .ir_valid(ir_valid),
    .exec_done(exec_done), .br_taken(br_taken), .br_target(br_target),
    .reti(reti), .halt_req(halt_req), .irq(irq), .irq_en(irq_en),
    .irq_ack(irq_ack), .in_isr(in_isr), .epc(epc), .halted(halted),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Program counter register owned by the environment.
  always @(posedge clk) begin
    if (rst) pc <= 16'h0000;
    else if (pc_load) pc <= pc_next;
    else if (pc_inc) pc <= pc + PC_INC;
  end

  function automatic vin_t vi(logic r, logic a, logic [15:0] rd, logic d, logic b,
                              logic [15:0] t, logic rt, logic h, logic q, logic e);
    vin_t v;
    v = '{r, a, rd, d, b, t, rt, h, q, e};
    return v;
  endfunction

  function automatic vout_t vo(logic rq, logic [15:0] ad, logic in, logic ld,
                               logic [15:0] nx, logic iv, logic ia, logic is,
                               logic hl, logic [15:0] irr, logic [15:0] ep);
    vout_t v;
    v = '{rq, ad, in, ld, nx, iv, ia, is, hl, irr, ep};
    return v;
  endfunction

  task automatic drive(input vin_t v);
    rst = v.rst; mem_ack = v.ack; mem_rdata = v.rdata; exec_done = v.done;
    br_taken = v.bt; br_target = v.tgt; reti = v.reti; halt_req = v.halt;
    irq = v.irq; irq_en = v.ien;
  endtask

  task automatic run_vec(input vin_t vin, input vout_t vexp);
    vout_t got, want;
    @(posedge clk); #1;
    drive(vin);
    exp_q.push_back(vexp);
    @(negedge clk);
    want = vout_t'(exp_q.pop_front());
    got = '{mem_req, mem_addr, pc_inc, pc_load, pc_next, ir_valid, irq_ack,
            in_isr, halted, ir, epc};
    if (!want.req) begin
      want.addr = '0;
      got.addr  = '0;
    end
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL cycle%0d outputs: got req=%b addr=%h inc=%b load=%b nxt=%h irv=%b iack=%b isr=%b hlt=%b ir=%h epc=%h | exp req=%b addr=%h inc=%b load=%b nxt=%h irv=%b iack=%b isr=%b hlt=%b ir=%h epc=%h",
               cyc, got.req, got.addr, got.inc, got.load, got.nxt, got.irv, got.iack,
               got.isr, got.hlt, got.ir, got.epc, want.req, want.addr, want.inc,
               want.load, want.nxt, want.irv, want.iack, want.isr, want.hlt,
               want.ir, want.epc);
    end
    if (pc_load && pc_inc) begin
      n_fail++;
      $display("FAIL cycle%0d load_inc_excl: got both=1 exp 0", cyc);
    end
    cyc++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset, sequential fetch, exec wait
    tbl.push_back('{vi(1,0,16'hDEAD,0,0,0,0,0,0,0), vo(0,0,0,0,0,0,0,0,0,16'h0,16'h0)});
    tbl.push_back('{vi(1,0,16'hDEAD,0,0,0,0,0,0,0), vo(0,0,0,0,0,0,0,0,0,16'h0,16'h0)});
    tbl.push_back('{vi(0,1,16'hA001,0,0,0,0,0,0,0), vo(1,16'h0000,1,0,0,0,0,0,0,16'h0,16'h0)});
    tbl.push_back('{vi(0,0,16'hDEAD,1,0,0,0,0,0,0), vo(0,0,0,0,0,1,0,0,0,16'hA001,16'h0)});
    tbl.push_back('{vi(0,1,16'hA002,0,0,0,0,0,0,0), vo(1,16'h0002,1,0,0,0,0,0,0,16'hA001,16'h0)});
    tbl.push_back('{vi(0,0,16'hDEAD,0,0,0,0,0,0,0), vo(0,0,0,0,0,1,0,0,0,16'hA002,16'h0)});
    tbl.push_back('{vi(0,0,16'hDEAD,1,0,0,0,0,0,0), vo(0,0,0,0,0,1,0,0,0,16'hA002,16'h0)});
    // three wait states then ack
    for (int k = 0; k < 3; k++)
      tbl.push_back('{vi(0,0,16'hDEAD,0,0,0,0,0,0,0), vo(1,16'h0004,0,0,0,0,0,0,0,16'hA002,16'h0)});
    tbl.push_back('{vi(0,1,16'hB004,0,0,0,0,0,0,0), vo(1,16'h0004,1,0,0,0,0,0,0,16'hA002,16'h0)});
    // odd branch target is aligned
    tbl.push_back('{vi(0,0,16'hDEAD,1,1,16'h0123,0,0,0,0), vo(0,0,0,1,16'h0122,1,0,0,0,16'hB004,16'h0)});
    tbl.push_back('{vi(0,1,16'hC122,0,0,0,0,0,0,0), vo(1,16'h0122,1,0,0,0,0,0,0,16'hB004,16'h0)});
    tbl.push_back('{vi(0,0,16'hDEAD,1,1,16'h000E,0,0,0,0), vo(0,0,0,1,16'h000E,1,0,0,0,16'hC122,16'h0)});
    tbl.push_back('{vi(0,1,16'hD00E,0,0,0,0,0,0,0), vo(1,16'h000E,1,0,0,0,0,0,0,16'hC122,16'h0)});
    // interrupt at pc 0x0010 with a simultaneous halt that must be dropped
    tbl.push_back('{vi(0,0,16'hDEAD,1,0,0,0,1,1,1), vo(0,0,0,1,16'h0004,1,1,0,0,16'hD00E,16'h0)});
    tbl.push_back('{vi(0,1,16'hE004,0,0,0,0,0,0,0), vo(1,16'h0004,1,0,0,0,0,1,0,16'hD00E,16'h0010)});
    tbl.push_back('{vi(0,0,16'hDEAD,1,0,0,0,0,1,1), vo(0,0,0,0,0,1,0,1,0,16'hE004,16'h0010)});
    tbl.push_back('{vi(0,1,16'hE006,0,0,0,0,0,0,0), vo(1,16'h0006,1,0,0,0,0,1,0,16'hE004,16'h0010)});
    tbl.push_back('{vi(0,0,16'hDEAD,1,0,0,1,0,1,1), vo(0,0,0,1,16'h0010,1,0,1,0,16'hE006,16'h0010)});
    tbl.push_back('{vi(0,1,16'hF010,0,0,0,0,0,0,0), vo(1,16'h0010,1,0,0,0,0,0,0,16'hE006,16'h0010)});
    // halt with interrupts disabled
    tbl.push_back('{vi(0,0,16'hDEAD,1,0,0,0,1,1,0), vo(0,0,0,0,0,1,0,0,0,16'hF010,16'h0010)});

    foreach (tbl[n]) run_vec(tbl[n].i, tbl[n].o);

    // sit in HALT for 10 cycles with stray acks, done strobes and masked irq
    for (int k = 0; k < 10; k++)
      run_vec(vi(0, 1'($urandom_range(0,1)), 16'hDEAD, 1'($urandom_range(0,1)), 0, 0, 0, 0,
                 1'($urandom_range(0,1)), 0),
              vo(0,0,0,0,0,0,0,0,1,16'hF010,16'h0010));
    // wake by interrupt: epc takes the halted pc
    run_vec(vi(0,0,16'hDEAD,0,0,0,0,0,1,1), vo(0,0,0,1,16'h0004,0,1,0,1,16'hF010,16'h0010));
    run_vec(vi(0,0,16'hDEAD,0,0,0,0,0,0,0), vo(1,16'h0004,0,0,0,0,0,1,0,16'hF010,16'h0012));
    run_vec(vi(0,0,16'hDEAD,0,0,0,0,0,0,0), vo(1,16'h0004,0,0,0,0,0,1,0,16'hF010,16'h0012));
    // reset mid-fetch with the ack landing in the reset cycle
    run_vec(vi(1,1,16'hBAD0,0,0,0,0,0,0,0), vo(0,0,0,0,0,0,0,1,0,16'hF010,16'h0012));
    run_vec(vi(0,1,16'h1234,0,0,0,0,0,0,0), vo(1,16'h0000,1,0,0,0,0,0,0,16'h0000,16'h0000));
    run_vec(vi(0,0,16'hDEAD,1,0,0,0,0,0,0), vo(0,0,0,0,0,1,0,0,0,16'h1234,16'h0000));
    run_vec(vi(0,0,16'hDEAD,0,0,0,0,0,0,0), vo(1,16'h0002,0,0,0,0,0,0,0,16'h1234,16'h0000));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
